// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator stage.
package mult_acc_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int INPUT_BIT_SIZE = 32;
  localparam int PROD_BIT_SIZE  = 2 * INPUT_BIT_SIZE;
  localparam int ACC_GUARD_BITS = 8;
  localparam int MAX_TERMS      = 16;

  // Counter must hold 0..max_terms inclusive.
  function automatic int cnt_bit_size(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input and group-result output handshakes of the product accumulator.
interface product_accumulator_if
  import mult_acc_pkg::*;
#(
  parameter int PROD_BIT_SIZE = mult_acc_pkg::PROD_BIT_SIZE,
  parameter int ACC_BIT_SIZE  = mult_acc_pkg::PROD_BIT_SIZE + ACC_GUARD_BITS,
  parameter int CNT_BIT_SIZE  = cnt_bit_size(mult_acc_pkg::MAX_TERMS)
);

  logic                     In_Valid;
  logic                     In_Ready;
  logic [PROD_BIT_SIZE-1:0] Prod;
  logic                     In_Last;
  logic                     Out_Valid;
  logic                     Out_Ready;
  logic [ACC_BIT_SIZE-1:0]  Acc_Out;
  logic [CNT_BIT_SIZE-1:0]  Term_Count;
  logic                     Overflow;

  modport master (
    output In_Valid, Prod, In_Last, Out_Ready,
    input  In_Ready, Out_Valid, Acc_Out, Term_Count, Overflow
  );

  modport slave (
    input  In_Valid, Prod, In_Last, Out_Ready,
    output In_Ready, Out_Valid, Acc_Out, Term_Count, Overflow
  );

endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Accumulator adder with carry out; ACC_SATURATE_EN clamps the sum to all-ones on carry.
module acc_adder #(
  parameter int ACC_BIT_SIZE  = 72,
  parameter int PROD_BIT_SIZE = 64
) (
  input  logic [ACC_BIT_SIZE-1:0]  i_a,
  input  logic [PROD_BIT_SIZE-1:0] i_b,
  output logic [ACC_BIT_SIZE-1:0]  o_sum,
  output logic                     o_carry
);

  logic [ACC_BIT_SIZE:0] w_raw;

  // Widened add; an all-ones accumulator plus any nonzero term carries again, so a clamp persists.
  always_comb begin
    w_raw   = {1'b0, i_a} + (ACC_BIT_SIZE + 1)'(i_b);
    o_carry = w_raw[ACC_BIT_SIZE];
`ifdef ACC_SATURATE_EN
    if (w_raw[ACC_BIT_SIZE]) begin
      o_sum = {ACC_BIT_SIZE{1'b1}};
    end else begin
      o_sum = w_raw[ACC_BIT_SIZE-1:0];
    end
`else
    o_sum = w_raw[ACC_BIT_SIZE-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of multiplier products (closed by In_Last or MAX_TERMS) and holds each result
// on a valid/ready port. ACC_SATURATE_EN selects clamping instead of wrapping on overflow.
module product_accumulator
  import mult_acc_pkg::*;
#(
  parameter int INPUT_BIT_SIZE = mult_acc_pkg::INPUT_BIT_SIZE,
  parameter int PROD_BIT_SIZE  = 2 * INPUT_BIT_SIZE,
  parameter int ACC_BIT_SIZE   = PROD_BIT_SIZE + ACC_GUARD_BITS,
  parameter int MAX_TERMS      = mult_acc_pkg::MAX_TERMS,
  parameter int CNT_BIT_SIZE   = cnt_bit_size(MAX_TERMS)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  product_accumulator_if.slave bus
);

  if (ACC_BIT_SIZE < PROD_BIT_SIZE) begin : g_acc_width_chk
    $error("ACC_BIT_SIZE must be >= PROD_BIT_SIZE");
  end
  if (PROD_BIT_SIZE != 2 * INPUT_BIT_SIZE) begin : g_prod_width_chk
    $error("PROD_BIT_SIZE must be 2*INPUT_BIT_SIZE");
  end

  state_t                  r_state;
  logic [ACC_BIT_SIZE-1:0] r_acc;
  logic [CNT_BIT_SIZE-1:0] r_cnt;
  logic                    r_ovf;
  logic [ACC_BIT_SIZE-1:0] r_acc_out;
  logic [CNT_BIT_SIZE-1:0] r_term_count;
  logic                    r_overflow;

  logic                    w_in_ready;
  logic                    w_accept;
  logic [ACC_BIT_SIZE-1:0] w_sum;
  logic                    w_carry;
  logic [CNT_BIT_SIZE-1:0] w_cnt_n;
  logic                    w_ovf_n;
  logic                    w_close;

  acc_adder #(
    .ACC_BIT_SIZE  (ACC_BIT_SIZE),
    .PROD_BIT_SIZE (PROD_BIT_SIZE)
  ) u_acc_adder (
    .i_a     (r_acc),
    .i_b     (bus.Prod),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Ready is combinational from Out_Ready so a closing term always has a free result slot.
  always_comb begin
    w_in_ready = (r_state == EMPTY) || bus.Out_Ready;
    w_accept   = bus.In_Valid && w_in_ready;
    w_cnt_n    = r_cnt + CNT_BIT_SIZE'(1);
    w_ovf_n    = r_ovf | w_carry;
    w_close    = bus.In_Last || (w_cnt_n == CNT_BIT_SIZE'(MAX_TERMS));
  end

  assign bus.In_Ready   = w_in_ready;
  assign bus.Out_Valid  = (r_state == HOLD);
  assign bus.Acc_Out    = r_acc_out;
  assign bus.Term_Count = r_term_count;
  assign bus.Overflow   = r_overflow;

  // Group accumulation and result-slot FSM; output registers are only written on a close.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= EMPTY;
      r_acc        <= {ACC_BIT_SIZE{1'b0}};
      r_cnt        <= {CNT_BIT_SIZE{1'b0}};
      r_ovf        <= 1'b0;
      r_acc_out    <= {ACC_BIT_SIZE{1'b0}};
      r_term_count <= {CNT_BIT_SIZE{1'b0}};
      r_overflow   <= 1'b0;
    end else if (w_accept && w_close) begin
      r_acc_out    <= w_sum;
      r_term_count <= w_cnt_n;
      r_overflow   <= w_ovf_n;
      r_acc        <= {ACC_BIT_SIZE{1'b0}};
      r_cnt        <= {CNT_BIT_SIZE{1'b0}};
      r_ovf        <= 1'b0;
      r_state      <= HOLD;
    end else begin
      if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_n;
        r_ovf <= w_ovf_n;
      end
      if ((r_state == HOLD) && bus.Out_Ready) begin
        r_state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench: default-width instance plus an 8-bit instance for overflow.
module tb_product_accumulator;
  import mult_acc_pkg::*;

  logic Clk;
  logic Reset;
  int   n_pass;
  int   n_total;

  product_accumulator_if #(.PROD_BIT_SIZE(64), .ACC_BIT_SIZE(72), .CNT_BIT_SIZE(5)) if_a ();
  product_accumulator_if #(.PROD_BIT_SIZE(8),  .ACC_BIT_SIZE(8),  .CNT_BIT_SIZE(5)) if_b ();

  product_accumulator #(
    .INPUT_BIT_SIZE (32),
    .PROD_BIT_SIZE  (64),
    .ACC_BIT_SIZE   (72),
    .MAX_TERMS      (16),
    .CNT_BIT_SIZE   (5)
  ) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_a.slave)
  );

  product_accumulator #(
    .INPUT_BIT_SIZE (4),
    .PROD_BIT_SIZE  (8),
    .ACC_BIT_SIZE   (8),
    .MAX_TERMS      (16),
    .CNT_BIT_SIZE   (5)
  ) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_b.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [63:0] p, input logic l);
    if_a.In_Valid = v;
    if_a.Prod     = p;
    if_a.In_Last  = l;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] p, input logic l);
    if_b.In_Valid = v;
    if_b.Prod     = p;
    if_b.In_Last  = l;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    drive_a(1'b0, 64'd0, 1'b0);
    drive_b(1'b0, 8'd0, 1'b0);
    if_a.Out_Ready = 1'b1;
    if_b.Out_Ready = 1'b1;
    tick();
    tick();
    n_total++; if (if_a.Out_Valid !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", if_a.Out_Valid); else n_pass++;
    n_total++; if (if_a.Acc_Out !== 72'd0) $display("FAIL rst_acc_out got %0d exp 0", if_a.Acc_Out); else n_pass++;
    n_total++; if (if_a.Term_Count !== 5'd0) $display("FAIL rst_term_count got %0d exp 0", if_a.Term_Count); else n_pass++;
    n_total++; if (if_a.Overflow !== 1'b0) $display("FAIL rst_overflow got %0b exp 0", if_a.Overflow); else n_pass++;
    Reset = 1'b1;
    tick();
    n_total++; if (if_a.In_Ready !== 1'b1) $display("FAIL rst_in_ready got %0b exp 1", if_a.In_Ready); else n_pass++;
    drive_a(1'b1, 64'd1, 1'b0); tick();
    drive_a(1'b1, 64'd2, 1'b0); tick();
    drive_a(1'b1, 64'd3, 1'b0); tick();
    drive_a(1'b0, 64'd0, 1'b0);
    Reset = 1'b0;
    #2;
    n_total++; if (if_a.Out_Valid !== 1'b0) $display("FAIL midrst_out_valid got %0b exp 0", if_a.Out_Valid); else n_pass++;
    Reset = 1'b1;
    tick();
    tick();
    n_total++; if (if_a.Out_Valid !== 1'b0) $display("FAIL postrst_out_valid got %0b exp 0", if_a.Out_Valid); else n_pass++;
    drive_a(1'b1, 64'd5, 1'b1); tick();
    drive_a(1'b0, 64'd0, 1'b0);
    n_total++; if (if_a.Out_Valid !== 1'b1) $display("FAIL postrst_valid got %0b exp 1", if_a.Out_Valid); else n_pass++;
    n_total++; if (if_a.Acc_Out !== 72'd5) $display("FAIL postrst_acc got %0d exp 5", if_a.Acc_Out); else n_pass++;
    n_total++; if (if_a.Term_Count !== 5'd1) $display("FAIL postrst_cnt got %0d exp 1", if_a.Term_Count); else n_pass++;
    tick();
    n_total++; if (if_a.Out_Valid !== 1'b0) $display("FAIL release_valid got %0b exp 0", if_a.Out_Valid); else n_pass++;
    n_total++; if (if_a.Acc_Out !== 72'd5) $display("FAIL release_acc_kept got %0d exp 5", if_a.Acc_Out); else n_pass++;
  endtask

  task automatic test_group();
    if_a.Out_Ready = 1'b1;
    drive_a(1'b1, 64'd3, 1'b0); tick();
    drive_a(1'b1, 64'd4, 1'b0); tick();
    n_total++; if (if_a.Out_Valid !== 1'b0) $display("FAIL group_early_valid got %0b exp 0", if_a.Out_Valid); else n_pass++;
    drive_a(1'b1, 64'd10, 1'b1); tick();
    drive_a(1'b0, 64'd0, 1'b0);
    n_total++; if (if_a.Out_Valid !== 1'b1) $display("FAIL group_valid got %0b exp 1", if_a.Out_Valid); else n_pass++;
    n_total++; if (if_a.Acc_Out !== 72'd17) $display("FAIL group_acc got %0d exp 17", if_a.Acc_Out); else n_pass++;
    n_total++; if (if_a.Term_Count !== 5'd3) $display("FAIL group_cnt got %0d exp 3", if_a.Term_Count); else n_pass++;
    n_total++; if (if_a.Overflow !== 1'b0) $display("FAIL group_ovf got %0b exp 0", if_a.Overflow); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    if_a.Out_Ready = 1'b0;
    drive_a(1'b1, 64'd20, 1'b1); tick();
    drive_a(1'b1, 64'd99, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_total++; if (if_a.In_Ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %0b exp 0", i, if_a.In_Ready); else n_pass++;
      n_total++; if (if_a.Acc_Out !== 72'd20) $display("FAIL bp_acc_stable cyc %0d got %0d exp 20", i, if_a.Acc_Out); else n_pass++;
      n_total++; if (if_a.Out_Valid !== 1'b1) $display("FAIL bp_valid cyc %0d got %0b exp 1", i, if_a.Out_Valid); else n_pass++;
      tick();
    end
    if_a.Out_Ready = 1'b1;
    drive_a(1'b1, 64'd9, 1'b1);
    #1;
    n_total++; if (if_a.In_Ready !== 1'b1) $display("FAIL bp_release_ready got %0b exp 1", if_a.In_Ready); else n_pass++;
    tick();
    drive_a(1'b0, 64'd0, 1'b0);
    n_total++; if (if_a.Acc_Out !== 72'd9) $display("FAIL bp_next_acc got %0d exp 9", if_a.Acc_Out); else n_pass++;
    n_total++; if (if_a.Out_Valid !== 1'b1) $display("FAIL bp_still_hold got %0b exp 1", if_a.Out_Valid); else n_pass++;
    tick();
  endtask

  task automatic test_forced_close();
    if_a.Out_Ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 64'd1, 1'b0);
      tick();
    end
    drive_a(1'b1, 64'd6, 1'b1);
    n_total++; if (if_a.Out_Valid !== 1'b1) $display("FAIL force_valid got %0b exp 1", if_a.Out_Valid); else n_pass++;
    n_total++; if (if_a.Acc_Out !== 72'd16) $display("FAIL force_acc got %0d exp 16", if_a.Acc_Out); else n_pass++;
    n_total++; if (if_a.Term_Count !== 5'd16) $display("FAIL force_cnt got %0d exp 16", if_a.Term_Count); else n_pass++;
    tick();
    drive_a(1'b0, 64'd0, 1'b0);
    n_total++; if (if_a.Acc_Out !== 72'd6) $display("FAIL force_next_acc got %0d exp 6", if_a.Acc_Out); else n_pass++;
    n_total++; if (if_a.Term_Count !== 5'd1) $display("FAIL force_next_cnt got %0d exp 1", if_a.Term_Count); else n_pass++;
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_acc;
`ifdef ACC_SATURATE_EN
    exp_acc = 8'd255;
`else
    exp_acc = 8'd44;
`endif
    if_b.Out_Ready = 1'b1;
    drive_b(1'b1, 8'd200, 1'b0); tick();
    drive_b(1'b1, 8'd100, 1'b1); tick();
    drive_b(1'b0, 8'd0, 1'b0);
    n_total++; if (if_b.Acc_Out !== exp_acc) $display("FAIL ovf_acc got %0d exp %0d", if_b.Acc_Out, exp_acc); else n_pass++;
    n_total++; if (if_b.Overflow !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", if_b.Overflow); else n_pass++;
    n_total++; if (if_b.Term_Count !== 5'd2) $display("FAIL ovf_cnt got %0d exp 2", if_b.Term_Count); else n_pass++;
    tick();
    drive_b(1'b1, 8'd10, 1'b0); tick();
    drive_b(1'b1, 8'd20, 1'b1); tick();
    drive_b(1'b0, 8'd0, 1'b0);
    n_total++; if (if_b.Acc_Out !== 8'd30) $display("FAIL ovf_next_acc got %0d exp 30", if_b.Acc_Out); else n_pass++;
    n_total++; if (if_b.Overflow !== 1'b0) $display("FAIL ovf_cleared got %0b exp 0", if_b.Overflow); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [3];
    vals[0] = 64'd7;
    vals[1] = 64'd8;
    vals[2] = 64'd9;
    if_a.Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, vals[i], 1'b1);
      #1;
      n_total++; if (if_a.In_Ready !== 1'b1) $display("FAIL b2b_ready idx %0d got %0b exp 1", i, if_a.In_Ready); else n_pass++;
      tick();
      n_total++; if (if_a.Acc_Out !== 72'(vals[i])) $display("FAIL b2b_acc idx %0d got %0d exp %0d", i, if_a.Acc_Out, vals[i]); else n_pass++;
      n_total++; if (if_a.Out_Valid !== 1'b1) $display("FAIL b2b_valid idx %0d got %0b exp 1", i, if_a.Out_Valid); else n_pass++;
    end
    drive_a(1'b0, 64'd0, 1'b0);
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_group();
    test_backpressure();
    test_forced_close();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
